mem_io_ctrl: RTL and testbench
==============================

MEM_IO_CTRL -- requirements
Module: mem_io_ctrl

Interface
REQ-001 Parameter WAIT_CYCLES, default 1: extra SRAM strobe cycles per access, range 0..7.
REQ-002 Parameter IO_ADDR, default 16'hFFFF: memory-mapped I/O address.
REQ-003 Clk  in  1  sole clock; all logic on rising edge.
REQ-004 Reset  in  1  synchronous, active-high reset.
REQ-005 Mem_CE, Mem_OE, Mem_WE  in  1 each  active-low request strobes from the control unit.
REQ-006 ADDR  in  16  MAR address.
REQ-007 Data_CPU_in  in  16  MDR write data.
REQ-008 Data_CPU_out  out  16  registered read data.
REQ-009 Rd_valid, Wr_done  out  1 each  one-cycle completion pulses.
REQ-010 Switches  in  16  asynchronous board switches.
REQ-011 HEX_Value  out  16  registered display value.
REQ-012 SRAM_ADDR  out  20  zero-extended ADDR.
REQ-013 SRAM_DQ  inout  16  SRAM data bus.
REQ-014 SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N  out  1 each  active-low SRAM controls.

Function
REQ-015 States: IDLE, RD_STROBE, RD_DONE, WR_SETUP, WR_PULSE, WR_HOLD, RELEASE.
REQ-016 IDLE: Mem_CE=0 and Mem_WE=0 -> WR_SETUP; else Mem_CE=0 and Mem_OE=0 -> RD_STROBE; WE wins if both low.
REQ-017 On leaving IDLE, ADDR and Data_CPU_in are latched; later changes ignored until RELEASE.
REQ-018 Latched address == IO_ADDR: read -> RD_DONE directly; write -> HEX_Value <= latched data, then WR_HOLD; no SRAM strobe either way.
REQ-019 RD_STROBE: SRAM_CE_N=0, SRAM_OE_N=0 for exactly WAIT_CYCLES+1 cycles (counter); SRAM_DQ sampled into Data_CPU_out on final cycle.
REQ-020 RD_DONE: Rd_valid=1 one cycle; I/O reads load synchronized Switches into Data_CPU_out here.
REQ-021 WR_SETUP: SRAM_CE_N=0, SRAM_WE_N=1, SRAM_DQ driven, one cycle.
REQ-022 WR_PULSE: SRAM_WE_N=0 for WAIT_CYCLES+1 cycles, SRAM_DQ driven.
REQ-023 WR_HOLD: SRAM_WE_N=1, SRAM_DQ still driven (SRAM writes only), Wr_done=1 one cycle.
REQ-024 RELEASE: wait until Mem_OE=1 and Mem_WE=1, then IDLE; a held strobe never retriggers.
REQ-025 SRAM_DQ driven only in WR_SETUP/WR_PULSE/WR_HOLD; high-Z otherwise.
REQ-026 SRAM_UB_N=SRAM_LB_N=0 whenever SRAM_CE_N=0; all SRAM controls 1 otherwise.
REQ-027 Switches pass a two-flop synchronizer before use.
REQ-028 Latency: SRAM read Rd_valid at cycle WAIT_CYCLES+2 after request; I/O read cycle 1; SRAM write Wr_done cycle WAIT_CYCLES+3.

Reset
REQ-029 Reset=1 at any edge, including mid-access: state IDLE, counter 0, SRAM_*_N=1, SRAM_DQ high-Z, Data_CPU_out=0, HEX_Value=0, Rd_valid=Wr_done=0, synchronizer flops 0.
REQ-030 After reset, an already-low strobe starts a new access on the first non-reset cycle.

Structure
REQ-031 Shared package mem_io_pkg holds the state enum and the IO_ADDR default constant.
REQ-032 Sub-module sync_2ff (parameterized width) implements the switch synchronizer.

Verification
REQ-033 WAIT_CYCLES=1, SRAM model holds 16'h1234 at 16'h0040, Mem_OE low 2 cycles -> SRAM_OE_N low 2 cycles, Rd_valid cycle 3, Data_CPU_out=16'h1234.
REQ-034 Write 16'hBEEF to 16'h0041 -> WE_N low 2 cycles, DQ=16'hBEEF across setup/pulse/hold, Wr_done once; read-back gives 16'hBEEF.
REQ-035 Write 16'h00A5 to 16'hFFFF -> HEX_Value=16'h00A5, SRAM_CE_N stays 1, Wr_done pulses.
REQ-036 Switches=16'h5A5A held 3 cycles, read 16'hFFFF -> Data_CPU_out=16'h5A5A, Rd_valid cycle 1, no SRAM strobe.
REQ-037 Mem_OE and Mem_WE low together -> write performed, no read strobe; strobes held 10 cycles -> exactly one access.
REQ-038 Reset asserted during WR_PULSE -> next edge SRAM_WE_N=1, DQ high-Z, HEX_Value=0, no Wr_done.

Source files
------------

// File: rtl/mem_io_pkg.sv
// -----------------------------------------------------------------------------
// mem_io_pkg
// Shared definitions for the memory / memory-mapped I/O controller:
//   - state_e          : controller state encoding
//   - IO_ADDR_DEFAULT  : default address of the memory-mapped I/O location
//   - CNT_W            : width of the strobe-length counter (covers 0..7 waits)
// -----------------------------------------------------------------------------
package mem_io_pkg;

    localparam logic [15:0] IO_ADDR_DEFAULT = 16'hFFFF;
    localparam int unsigned CNT_W           = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_STROBE,
        ST_RD_DONE,
        ST_WR_SETUP,
        ST_WR_PULSE,
        ST_WR_HOLD,
        ST_RELEASE
    } state_e;

endpackage

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer for a bus of quasi-static asynchronous inputs
// (board switches). Each bit is synchronized independently, so a bus that
// changes while sampled may be seen partially updated for one cycle.
//
// Ports:
//   clk_i  in   1      clock
//   rst_i  in   1      synchronous active-high reset (clears both stages)
//   d_i    in   WIDTH  asynchronous input
//   q_o    out  WIDTH  synchronized output (two cycles of latency)
// -----------------------------------------------------------------------------
module sync_2ff #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // NOTE: sequential state uses non-blocking assignments so both stages
    // sample their inputs from before the edge; blocking here would collapse
    // the two flops into one.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/mem_io_ctrl.sv
// -----------------------------------------------------------------------------
// mem_io_ctrl
// Bridges CPU memory requests to an asynchronous 16-bit SRAM, with one
// memory-mapped I/O location: reads of IO_ADDR return the (synchronized)
// board switches, writes to IO_ADDR update the hex display register.
//
// Parameters:
//   WAIT_CYCLES  extra SRAM strobe cycles per access (0..7)
//   IO_ADDR      address decoded as the I/O location
//
// Ports:
//   Clk            in    1   clock, rising edge
//   Reset          in    1   synchronous active-high reset
//   Mem_CE/OE/WE   in    1   active-low request strobes from the control unit
//   ADDR           in    16  request address (MAR)
//   Data_CPU_in    in    16  write data (MDR)
//   Data_CPU_out   out   16  registered read data
//   Rd_valid       out   1   one-cycle pulse: Data_CPU_out holds read result
//   Wr_done        out   1   one-cycle pulse: write finished
//   Switches       in    16  asynchronous board switches
//   HEX_Value      out   16  registered display value
//   SRAM_ADDR      out   20  zero-extended latched address
//   SRAM_DQ        inout 16  SRAM data bus
//   SRAM_*_N       out   1   active-low SRAM controls (registered)
// -----------------------------------------------------------------------------
module mem_io_ctrl
    import mem_io_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter logic [15:0] IO_ADDR     = IO_ADDR_DEFAULT
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Mem_CE,
    input  logic        Mem_OE,
    input  logic        Mem_WE,
    input  logic [15:0] ADDR,
    input  logic [15:0] Data_CPU_in,
    output logic [15:0] Data_CPU_out,
    output logic        Rd_valid,
    output logic        Wr_done,
    input  logic [15:0] Switches,
    output logic [15:0] HEX_Value,
    output logic [19:0] SRAM_ADDR,
    inout  wire  [15:0] SRAM_DQ,
    output logic        SRAM_CE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_WE_N,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      addr_q, addr_d;
    logic [15:0]      wdata_q, wdata_d;
    logic             io_q, io_d;

    logic [15:0]      rdata_q;
    logic [15:0]      hex_q;
    logic             rd_valid_q;
    logic             wr_done_q;
    logic             ce_n_q, oe_n_q, we_n_q;
    logic             dq_oe_q;

    logic [15:0]      sw_sync;
    logic             req_rd, req_wr;
    logic             io_hit;
    logic             sram_active_d;
    logic             dq_drive_d;

    sync_2ff #(
        .WIDTH (16)
    ) u_sw_sync (
        .clk_i (Clk),
        .rst_i (Reset),
        .d_i   (Switches),
        .q_o   (sw_sync)
    );

    // Write has priority when both strobes are low together.
    assign req_wr = !Mem_CE && !Mem_WE;
    assign req_rd = !Mem_CE && !Mem_OE && Mem_WE;
    assign io_hit = (ADDR == IO_ADDR);

    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        io_d    = io_q;

        unique case (state_q)
            ST_IDLE: begin
                if (req_wr || req_rd) begin
                    // Capture the request; later changes on ADDR / data are
                    // ignored until the controller returns to idle.
                    addr_d  = ADDR;
                    wdata_d = Data_CPU_in;
                    io_d    = io_hit;
                    cnt_d   = '0;
                    if (req_wr) begin
                        state_d = io_hit ? ST_WR_HOLD : ST_WR_SETUP;
                    end else begin
                        state_d = io_hit ? ST_RD_DONE : ST_RD_STROBE;
                    end
                end
            end
            ST_RD_STROBE: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_RD_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RD_DONE:  state_d = ST_RELEASE;
            ST_WR_SETUP: state_d = ST_WR_PULSE;
            ST_WR_PULSE: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_WR_HOLD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WR_HOLD:  state_d = ST_RELEASE;
            ST_RELEASE: begin
                // Wait for the strobes to go away so a held request cannot
                // start a second access.
                if (Mem_OE && Mem_WE) begin
                    state_d = ST_IDLE;
                end
            end
            default:     state_d = ST_IDLE;
        endcase
    end

    // SRAM controls are registered from the next state so they are clean
    // flop outputs aligned with the state they belong to. An I/O write passes
    // through WR_HOLD only to pulse Wr_done and never touches the SRAM.
    assign sram_active_d = (state_d == ST_RD_STROBE) ||
                           (state_d == ST_WR_SETUP)  ||
                           (state_d == ST_WR_PULSE)  ||
                           ((state_d == ST_WR_HOLD) && !io_d);
    assign dq_drive_d    = (state_d == ST_WR_SETUP)  ||
                           (state_d == ST_WR_PULSE)  ||
                           ((state_d == ST_WR_HOLD) && !io_d);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            io_q       <= 1'b0;
            rdata_q    <= '0;
            hex_q      <= '0;
            rd_valid_q <= 1'b0;
            wr_done_q  <= 1'b0;
            ce_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
            we_n_q     <= 1'b1;
            dq_oe_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            io_q       <= io_d;
            rd_valid_q <= (state_d == ST_RD_DONE);
            wr_done_q  <= (state_d == ST_WR_HOLD);
            ce_n_q     <= !sram_active_d;
            oe_n_q     <= (state_d != ST_RD_STROBE);
            we_n_q     <= (state_d != ST_WR_PULSE);
            dq_oe_q    <= dq_drive_d;

            // SRAM read data is captured at the end of the last strobe cycle.
            if ((state_q == ST_RD_STROBE) && (cnt_q == CNT_LAST)) begin
                rdata_q <= SRAM_DQ;
            end
            if ((state_q == ST_IDLE) && (state_d == ST_RD_DONE)) begin
                rdata_q <= sw_sync;
            end
            if ((state_q == ST_IDLE) && (state_d == ST_WR_HOLD)) begin
                hex_q <= Data_CPU_in;
            end
        end
    end

    // NOTE: the latched address and write data are pure datapath; every use
    // is qualified by reset-cleared control, so they carry no reset.
    always_ff @(posedge Clk) begin
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
    end

    assign SRAM_DQ      = dq_oe_q ? wdata_q : 16'hzzzz;
    assign SRAM_ADDR    = {4'h0, addr_q};
    assign SRAM_CE_N    = ce_n_q;
    assign SRAM_OE_N    = oe_n_q;
    assign SRAM_WE_N    = we_n_q;
    assign SRAM_UB_N    = ce_n_q;
    assign SRAM_LB_N    = ce_n_q;
    assign Data_CPU_out = rdata_q;
    assign HEX_Value    = hex_q;
    assign Rd_valid     = rd_valid_q;
    assign Wr_done      = wr_done_q;

endmodule

// File: tb/tb_mem_io_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_io_ctrl
// Bench for mem_io_ctrl with WAIT_CYCLES=1. A behavioural SRAM chip sits on
// the data bus. An expectation model turns each request into a per-cycle
// timeline from the latency rules; one compare process checks every cycle
// against that timeline, and literal expectations pin the key scenarios.
// -----------------------------------------------------------------------------
module tb_mem_io_ctrl;

    localparam int          W      = 1;
    localparam int          NCYC   = 1024;
    localparam logic [15:0] IOA    = 16'hFFFF;
    localparam int          DQ_OFF = 0;   // bus must be released
    localparam int          DQ_DRV = 1;   // controller must drive e_dq
    localparam int          DQ_EXT = 2;   // SRAM chip drives the bus

    logic        clk = 1'b0;
    logic        Reset;
    logic        Mem_CE, Mem_OE, Mem_WE;
    logic [15:0] ADDR, Data_CPU_in, Switches;
    logic [15:0] Data_CPU_out, HEX_Value;
    logic        Rd_valid, Wr_done;
    logic [19:0] SRAM_ADDR;
    logic        SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N;
    wire  [15:0] dq_bus;

    always #5 clk = ~clk;

    mem_io_ctrl #(
        .WAIT_CYCLES (W),
        .IO_ADDR     (IOA)
    ) dut (
        .Clk          (clk),
        .Reset        (Reset),
        .Mem_CE       (Mem_CE),
        .Mem_OE       (Mem_OE),
        .Mem_WE       (Mem_WE),
        .ADDR         (ADDR),
        .Data_CPU_in  (Data_CPU_in),
        .Data_CPU_out (Data_CPU_out),
        .Rd_valid     (Rd_valid),
        .Wr_done      (Wr_done),
        .Switches     (Switches),
        .HEX_Value    (HEX_Value),
        .SRAM_ADDR    (SRAM_ADDR),
        .SRAM_DQ      (dq_bus),
        .SRAM_CE_N    (SRAM_CE_N),
        .SRAM_OE_N    (SRAM_OE_N),
        .SRAM_WE_N    (SRAM_WE_N),
        .SRAM_UB_N    (SRAM_UB_N),
        .SRAM_LB_N    (SRAM_LB_N)
    );

    // ---------------- SRAM chip ----------------
    logic [15:0] chip_mem [0:65535];
    logic [15:0] chip_rd;
    assign chip_rd = chip_mem[SRAM_ADDR[15:0]];
    assign dq_bus  = (!SRAM_CE_N && !SRAM_OE_N && SRAM_WE_N) ? chip_rd : 16'hzzzz;

    initial begin
        for (int i = 0; i < 65536; i++) chip_mem[i] = 16'h0000;
        chip_mem[16'h0040] = 16'h1234;
        forever begin
            @(negedge clk);
            if (!SRAM_CE_N && !SRAM_WE_N) chip_mem[SRAM_ADDR[15:0]] = dq_bus;
        end
    end

    // ---------------- bookkeeping ----------------
    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    // ---------------- expectation model ----------------
    logic        e_ce_n  [NCYC];
    logic        e_oe_n  [NCYC];
    logic        e_we_n  [NCYC];
    logic        e_rdv   [NCYC];
    logic        e_wrd   [NCYC];
    int          e_dqk   [NCYC];
    logic [15:0] e_dq    [NCYC];
    logic [15:0] e_addr  [NCYC];
    logic        ev_dout [NCYC];
    logic [15:0] ev_doutv[NCYC];
    logic        ev_hex  [NCYC];
    logic [15:0] ev_hexv [NCYC];
    logic [15:0] model_mem [int unsigned];
    logic [15:0] exp_dout, exp_hex;

    function automatic logic [15:0] mem_rd(input logic [15:0] a);
        if (a == 16'h0040 && !model_mem.exists(32'(a))) return 16'h1234;
        return model_mem.exists(32'(a)) ? model_mem[32'(a)] : 16'h0000;
    endfunction

    // Everything from cycle c onwards returns to idle; registers read 0 at c.
    task automatic model_reset(input int c);
        for (int k = c; k < NCYC; k++) begin
            e_ce_n[k] = 1'b1; e_oe_n[k] = 1'b1; e_we_n[k] = 1'b1;
            e_rdv[k]  = 1'b0; e_wrd[k]  = 1'b0; e_dqk[k]  = DQ_OFF;
            e_dq[k]   = '0;   e_addr[k] = '0;
            ev_dout[k] = 1'b0; ev_doutv[k] = '0; ev_hex[k] = 1'b0; ev_hexv[k] = '0;
        end
        ev_dout[c] = 1'b1;
        ev_hex[c]  = 1'b1;
    endtask

    // Request seen by the controller at the end of cycle c0.
    task automatic model_access(input int c0, input bit is_wr, input logic [15:0] a,
                                input logic [15:0] d, input logic [15:0] sw);
        if (a == IOA) begin
            if (is_wr) begin
                e_wrd[c0+1] = 1'b1; ev_hex[c0+1] = 1'b1; ev_hexv[c0+1] = d;
            end else begin
                e_rdv[c0+1] = 1'b1; ev_dout[c0+1] = 1'b1; ev_doutv[c0+1] = sw;
            end
        end else if (!is_wr) begin
            for (int k = 1; k <= W + 1; k++) begin
                e_ce_n[c0+k] = 1'b0; e_oe_n[c0+k] = 1'b0;
                e_dqk[c0+k]  = DQ_EXT; e_addr[c0+k] = a;
            end
            e_rdv[c0+W+2] = 1'b1; ev_dout[c0+W+2] = 1'b1; ev_doutv[c0+W+2] = mem_rd(a);
        end else begin
            for (int k = 1; k <= W + 3; k++) begin
                e_ce_n[c0+k] = 1'b0; e_dqk[c0+k] = DQ_DRV;
                e_dq[c0+k]   = d;    e_addr[c0+k] = a;
                if (k >= 2 && k <= W + 2) e_we_n[c0+k] = 1'b0;
            end
            e_wrd[c0+W+3] = 1'b1;
            model_mem[32'(a)] = d;
        end
    endtask

    // ---------------- per-cycle compare + observation counters ----------------
    int oe_low, we_low, ce_low, rdv_n, wrd_n, rdv_cyc, wrd_cyc, dq_beef;

    task automatic clr_mon();
        oe_low = 0; we_low = 0; ce_low = 0; rdv_n = 0; wrd_n = 0;
        rdv_cyc = -1; wrd_cyc = -1; dq_beef = 0;
    endtask

    initial begin
        logic rel;
        forever begin
            @(negedge clk);
            if (cyc >= 1 && cyc < NCYC) begin
                if (ev_dout[cyc]) exp_dout = ev_doutv[cyc];
                if (ev_hex[cyc])  exp_hex  = ev_hexv[cyc];
                check("ce_n",  32'(SRAM_CE_N),    32'(e_ce_n[cyc]));
                check("oe_n",  32'(SRAM_OE_N),    32'(e_oe_n[cyc]));
                check("we_n",  32'(SRAM_WE_N),    32'(e_we_n[cyc]));
                check("ub_n",  32'(SRAM_UB_N),    32'(e_ce_n[cyc]));
                check("lb_n",  32'(SRAM_LB_N),    32'(e_ce_n[cyc]));
                check("rdv",   32'(Rd_valid),     32'(e_rdv[cyc]));
                check("wrd",   32'(Wr_done),      32'(e_wrd[cyc]));
                check("dout",  32'(Data_CPU_out), 32'(exp_dout));
                check("hex",   32'(HEX_Value),    32'(exp_hex));
                if (!e_ce_n[cyc]) check("sram_addr", 32'(SRAM_ADDR), {12'h0, 4'h0, e_addr[cyc]});
                if (e_dqk[cyc] == DQ_DRV) check("dq", 32'(dq_bus), 32'(e_dq[cyc]));
                if (e_dqk[cyc] == DQ_OFF) begin
                    rel = (dq_bus === 16'hzzzz) || (dq_bus === 16'h0000);
                    check("dq_released", 32'(rel), 32'd1);
                end
            end
            if (!SRAM_OE_N) oe_low++;
            if (!SRAM_WE_N) we_low++;
            if (!SRAM_CE_N) ce_low++;
            if (Rd_valid) begin rdv_n++; rdv_cyc = cyc; end
            if (Wr_done)  begin wrd_n++; wrd_cyc = cyc; end
            if (!SRAM_CE_N && SRAM_OE_N && dq_bus === 16'hBEEF) dq_beef++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Strobes low for 'hold' cycles; request fields are scrambled after the
    // first cycle to show that the controller works from its latched copy.
    task automatic access(input bit is_wr, input bit both, input logic [15:0] a,
                          input logic [15:0] d, input int hold, output int c0);
        c0     = cyc;
        Mem_CE = 1'b0;
        Mem_WE = is_wr ? 1'b0 : 1'b1;
        Mem_OE = (!is_wr || both) ? 1'b0 : 1'b1;
        ADDR = a;
        Data_CPU_in = d;
        model_access(c0, is_wr, a, d, Switches);
        tick(1);
        ADDR = a ^ 16'h0F0F;
        Data_CPU_in = ~d;
        if (hold > 1) tick(hold - 1);
        Mem_CE = 1'b1; Mem_OE = 1'b1; Mem_WE = 1'b1;
        tick(W + 6);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog cycle=%0d got=timeout want=finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0, cr;
        Reset = 1'b1; Mem_CE = 1'b1; Mem_OE = 1'b1; Mem_WE = 1'b1;
        ADDR = '0; Data_CPU_in = '0; Switches = '0;
        exp_dout = '0; exp_hex = '0;
        clr_mon();
        model_reset(0);
        model_reset(1);

        // Reset state
        tick(3);
        check("rst_dout", 32'(Data_CPU_out), 32'h0);
        check("rst_hex",  32'(HEX_Value),    32'h0);
        check("rst_ce_n", 32'(SRAM_CE_N),    32'h1);
        Reset = 1'b0;
        tick(2);

        // SRAM read of 0x0040, OE held two cycles
        clr_mon();
        access(1'b0, 1'b0, 16'h0040, 16'h0000, 2, c0);
        check("rd_oe_cycles",  32'(oe_low),       32'd2);
        check("rd_valid_lat",  32'(rdv_cyc - c0), 32'd3);
        check("rd_valid_once", 32'(rdv_n),        32'd1);
        check("rd_data",       32'(Data_CPU_out), 32'h1234);

        // SRAM write of 0xBEEF to 0x0041, then read it back
        clr_mon();
        access(1'b1, 1'b0, 16'h0041, 16'hBEEF, 2, c0);
        check("wr_we_cycles", 32'(we_low),       32'd2);
        check("wr_dq_cycles", 32'(dq_beef),      32'd4);
        check("wr_done_once", 32'(wrd_n),        32'd1);
        check("wr_done_lat",  32'(wrd_cyc - c0), 32'd4);
        access(1'b0, 1'b0, 16'h0041, 16'h0000, 1, c0);
        check("readback", 32'(Data_CPU_out), 32'hBEEF);

        // I/O write to the display register
        clr_mon();
        access(1'b1, 1'b0, IOA, 16'h00A5, 1, c0);
        check("io_wr_hex",  32'(HEX_Value),    32'h00A5);
        check("io_wr_ce",   32'(ce_low),       32'd0);
        check("io_wr_done", 32'(wrd_n),        32'd1);
        check("io_wr_lat",  32'(wrd_cyc - c0), 32'd1);

        // I/O read of the switches
        Switches = 16'h5A5A;
        tick(3);
        clr_mon();
        access(1'b0, 1'b0, IOA, 16'h0000, 1, c0);
        check("io_rd_data", 32'(Data_CPU_out), 32'h5A5A);
        check("io_rd_lat",  32'(rdv_cyc - c0), 32'd1);
        check("io_rd_ce",   32'(ce_low),       32'd0);

        // OE and WE low together, held 10 cycles: exactly one write
        clr_mon();
        access(1'b1, 1'b1, 16'h0050, 16'h1357, 10, c0);
        check("both_no_oe",  32'(oe_low), 32'd0);
        check("both_we",     32'(we_low), 32'd2);
        check("both_wr_one", 32'(wrd_n),  32'd1);
        check("both_no_rd",  32'(rdv_n),  32'd0);
        access(1'b0, 1'b0, 16'h0050, 16'h0000, 1, c0);
        check("both_readback", 32'(Data_CPU_out), 32'h1357);

        // Reset during WR_PULSE (the aborted write is never read back)
        clr_mon();
        c0 = cyc;
        Mem_CE = 1'b0; Mem_WE = 1'b0; ADDR = 16'h0042; Data_CPU_in = 16'h7777;
        model_access(c0, 1'b1, 16'h0042, 16'h7777, Switches);
        tick(2);
        Reset = 1'b1; Mem_CE = 1'b1; Mem_WE = 1'b1;
        model_reset(c0 + 3);
        tick(1);
        check("rst_mid_we_n", 32'(SRAM_WE_N), 32'h1);
        check("rst_mid_hex",  32'(HEX_Value), 32'h0);
        Reset = 1'b0;
        tick(W + 6);
        check("rst_mid_no_done", 32'(wrd_n), 32'd0);

        // Strobe already low during reset starts an access right after it
        clr_mon();
        Reset = 1'b1; Mem_CE = 1'b0; Mem_OE = 1'b0; ADDR = 16'h0041;
        model_reset(cyc + 1);
        tick(2);
        cr = cyc;
        Reset = 1'b0;
        model_access(cr, 1'b0, 16'h0041, 16'h0000, Switches);
        tick(1);
        Mem_CE = 1'b1; Mem_OE = 1'b1;
        tick(W + 6);
        check("post_rst_rd",  32'(Data_CPU_out), 32'hBEEF);
        check("post_rst_lat", 32'(rdv_cyc - cr), 32'd3);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
